// File: rtl/lcd_timing_generator.sv
// Raster timing generator and pixel register stage for a parallel RGB LCD panel.
// Optional colour-bar source: define LCD_TEST_PATTERN_EN to add the test_pattern input.
module lcd_timing_generator #(
  parameter int unsigned H_ACTIVE         = 800,
  parameter int unsigned H_FRONT          = 40,
  parameter int unsigned H_SYNC           = 48,
  parameter int unsigned H_BACK           = 40,
  parameter int unsigned V_ACTIVE         = 480,
  parameter int unsigned V_FRONT          = 13,
  parameter int unsigned V_SYNC           = 3,
  parameter int unsigned V_BACK           = 29,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  input  logic [7:0]  fb_red,
  input  logic [7:0]  fb_green,
  input  logic [7:0]  fb_blue,
  output logic        lcd_tick,
  output logic        lcd_next_frame,
  output logic        lcd_data_enable,
  output logic        lcd_pclk,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic        lcd_de,
  output logic [7:0]  lcd_r,
  output logic [7:0]  lcd_g,
  output logic [7:0]  lcd_b,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

  logic          tick_q, tick_d;
  logic [HW-1:0] h_count_q, h_count_d;
  logic [VW-1:0] v_count_q, v_count_d;
  logic          de_q, de_d;
  logic          next_frame_q, next_frame_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          pde_q, pde_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hs_act, vs_act;
  logic [7:0]    pix_r, pix_g, pix_b;

  always_comb begin
    hs_act = (32'(h_count_q) >= H_ACTIVE + H_FRONT) &&
             (32'(h_count_q) <  H_ACTIVE + H_FRONT + H_SYNC);
    vs_act = (32'(v_count_q) >= V_ACTIVE + V_FRONT) &&
             (32'(v_count_q) <  V_ACTIVE + V_FRONT + V_SYNC);
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  always_comb begin
    bar_idx = 3'((32'(h_count_q) * 32'd8) / H_ACTIVE);
    pix_r   = fb_red;
    pix_g   = fb_green;
    pix_b   = fb_blue;
    if (test_pattern) begin
      pix_r = {8{bar_idx[0]}};
      pix_g = {8{bar_idx[1]}};
      pix_b = {8{bar_idx[2]}};
    end
  end
`else
  always_comb begin
    pix_r = fb_red;
    pix_g = fb_green;
    pix_b = fb_blue;
  end
`endif

  always_comb begin
    tick_d        = ~tick_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    next_frame_d  = 1'b0;
    frame_count_d = frame_count_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    pde_d         = pde_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    if (tick_q) begin
      if (h_count_q == H_LAST) begin
        h_count_d    = '0;
        v_count_d    = (v_count_q == V_LAST) ? '0 : v_count_q + VW'(1);
        next_frame_d = (32'(v_count_d) == V_ACTIVE);
      end else begin
        h_count_d = h_count_q + HW'(1);
      end
      // Panel stage latches the pixel that was current during this tick.
      pde_d   = de_q;
      hsync_d = hs_act ? SYNC_ACTIVE_HIGH : SYNC_IDLE;
      vsync_d = vs_act ? SYNC_ACTIVE_HIGH : SYNC_IDLE;
      r_d     = de_q ? pix_r : 8'h00;
      g_d     = de_q ? pix_g : 8'h00;
      b_d     = de_q ? pix_b : 8'h00;
    end
    if (next_frame_d) frame_count_d = frame_count_q + 16'd1;
    // DE follows the upcoming counters so it stays flat across both clocks of a pixel.
    de_d = (32'(h_count_d) < H_ACTIVE) && (32'(v_count_d) < V_ACTIVE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_q        <= 1'b0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      de_q          <= 1'b0;
      next_frame_q  <= 1'b0;
      frame_count_q <= 16'd0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      pde_q         <= 1'b0;
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      b_q           <= 8'h00;
    end else begin
      tick_q        <= tick_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      de_q          <= de_d;
      next_frame_q  <= next_frame_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pde_q         <= pde_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign lcd_tick        = tick_q;
  assign lcd_pclk        = ~tick_q;
  assign lcd_next_frame  = next_frame_q;
  assign lcd_data_enable = de_q;
  assign lcd_hsync       = hsync_q;
  assign lcd_vsync       = vsync_q;
  assign lcd_de          = pde_q;
  assign lcd_r           = r_q;
  assign lcd_g           = g_q;
  assign lcd_b           = b_q;
  assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_lcd_timing_generator.sv
// Self-checking bench for lcd_timing_generator on a 7x5 raster (4/1/1/1, 2/1/1/1).
// Expected values come from closed-form functions of clocks-since-reset plus a pixel queue.
module tb_lcd_timing_generator;

  localparam int HT      = 7;
  localparam int VT      = 5;
  localparam int HA      = 4;
  localparam int VA      = 2;
  localparam int FRAME_P = HT * VT;
  localparam int NF_P    = VA * HT;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  fb_red = 8'h00, fb_green = 8'h00, fb_blue = 8'h00;
  logic        lcd_tick, lcd_next_frame, lcd_data_enable, lcd_pclk;
  logic        lcd_hsync, lcd_vsync, lcd_de;
  logic [7:0]  lcd_r, lcd_g, lcd_b;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int c        = 0;
  logic [23:0] exp_q[$];

  always #5 clock = ~clock;

`ifdef LCD_TEST_PATTERN_EN
  localparam int HT_TP = 11;
  logic       test_pattern    = 1'b0;
  logic       tp_test_pattern = 1'b1;
  logic       tp_tick, tp_nf, tp_den, tp_pclk, tp_hs, tp_vs, tp_de;
  logic [7:0] tp_r, tp_g, tp_b;
  logic [15:0] tp_fc;
`endif

  lcd_timing_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(1'b0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
`ifdef LCD_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .fb_red(fb_red), .fb_green(fb_green), .fb_blue(fb_blue),
    .lcd_tick(lcd_tick), .lcd_next_frame(lcd_next_frame),
    .lcd_data_enable(lcd_data_enable), .lcd_pclk(lcd_pclk),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .frame_count(frame_count)
  );

`ifdef LCD_TEST_PATTERN_EN
  lcd_timing_generator #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(1'b0)
  ) dut_tp (
    .clock(clock), .reset_n(reset_n), .test_pattern(tp_test_pattern),
    .fb_red(fb_red), .fb_green(fb_green), .fb_blue(fb_blue),
    .lcd_tick(tp_tick), .lcd_next_frame(tp_nf),
    .lcd_data_enable(tp_den), .lcd_pclk(tp_pclk),
    .lcd_hsync(tp_hs), .lcd_vsync(tp_vs), .lcd_de(tp_de),
    .lcd_r(tp_r), .lcd_g(tp_g), .lcd_b(tp_b),
    .frame_count(tp_fc)
  );
`endif

  function automatic bit active(input int p);
    return ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (c=%0d t=%0t)", tag, got, exp, c, $time);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_tick"}, 32'(lcd_tick), 0);
    check_eq({pfx, "_pclk"}, 32'(lcd_pclk), 1);
    check_eq({pfx, "_nf"}, 32'(lcd_next_frame), 0);
    check_eq({pfx, "_den"}, 32'(lcd_data_enable), 0);
    check_eq({pfx, "_hs"}, 32'(lcd_hsync), 1);
    check_eq({pfx, "_vs"}, 32'(lcd_vsync), 1);
    check_eq({pfx, "_de"}, 32'(lcd_de), 0);
    check_eq({pfx, "_rgb"}, 32'({lcd_r, lcd_g, lcd_b}), 0);
    check_eq({pfx, "_fc"}, 32'(frame_count), 0);
`ifdef LCD_TEST_PATTERN_EN
    check_eq({pfx, "_tp_rgb"}, 32'({tp_r, tp_g, tp_b}), 0);
`endif
  endtask

  task automatic check_cycle();
    int p, pp, e_fc;
    logic [23:0] e;
    p = c / 2;
    e_fc = (p >= NF_P) ? ((p - NF_P) / FRAME_P + 1) : 0;
    check_eq("tick", 32'(lcd_tick), 32'(c % 2));
    check_eq("pclk", 32'(lcd_pclk), 32'(1 - (c % 2)));
    check_eq("den", 32'(lcd_data_enable), 32'((c >= 1) && active(p)));
    check_eq("next_frame", 32'(lcd_next_frame),
             32'((c >= 2) && (c % 2 == 0) && (p % FRAME_P == NF_P)));
    check_eq("frame_count", 32'(frame_count), 32'(e_fc));
    if (c < 2) begin
      check_eq("hs_idle", 32'(lcd_hsync), 1);
      check_eq("vs_idle", 32'(lcd_vsync), 1);
      check_eq("de_idle", 32'(lcd_de), 0);
      check_eq("rgb_idle", 32'({lcd_r, lcd_g, lcd_b}), 0);
    end else begin
      pp = p - 1;
      check_eq("hsync", 32'(lcd_hsync), 32'((pp % HT) != 5));
      check_eq("vsync", 32'(lcd_vsync), 32'(((pp / HT) % VT) != 3));
      check_eq("lcd_de", 32'(lcd_de), 32'(active(pp)));
      if (c % 2 == 0) begin
        check_eq("sb_depth", 32'(exp_q.size()), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(e));
        end
      end
    end
`ifdef LCD_TEST_PATTERN_EN
    if (c >= 2) begin
      pp = p - 1;
      if (((pp % HT_TP) < 8) && (((pp / HT_TP) % VT) < VA)) begin
        e = {{8{pp[0]}}, {8{pp[1]}}, {8{pp[2]}}};
        e = {{8{(pp % HT_TP) % 2 == 1}}, {8{((pp % HT_TP) / 2) % 2 == 1}},
             {8{((pp % HT_TP) / 4) % 2 == 1}}};
      end else begin
        e = 24'h0;
      end
      check_eq("tp_rgb", 32'({tp_r, tp_g, tp_b}), 32'(e));
    end
`endif
  endtask

  task automatic drive_pixel();
    int p;
    p = c / 2;
    fb_red   = active(p) ? 8'(p % HT) : 8'hAA;
    fb_green = 8'($urandom_range(0, 255));
    fb_blue  = 8'($urandom_range(0, 255));
    if (c % 2 == 1)
      exp_q.push_back(active(p) ? {fb_red, fb_green, fb_blue} : 24'h0);
  endtask

  task automatic step();
    @(posedge clock);
    c++;
    @(negedge clock);
    check_cycle();
    drive_pixel();
  endtask

  task automatic release_reset();
    @(negedge clock);
    exp_q.delete();
    c = 0;
    reset_n = 1'b1;
    drive_pixel();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("rst");

    release_reset();
    repeat (200) step();
    for (int k = 0; k < 100 && !((c % 2 == 0) && ((c / 2) % FRAME_P == 9)); k++) step();
    check_eq("mid_pos", 32'((c / 2) % FRAME_P), 9);

    #2 reset_n = 1'b0;
    #1 check_reset_values("mid_rst");
    repeat (3) begin
      @(negedge clock);
      check_eq("rst_no_nf", 32'(lcd_next_frame), 0);
    end

    release_reset();
    repeat (90) step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
